elev_call_scheduler: RTL
========================

# elev_call_scheduler

Call-collecting scheduler for the 4-floor elevator. It latches hall and cab button presses into pending-request registers and tracks the car position from the floor sensors. It picks the travel direction with a collective (SCAN) policy, stops at served floors, runs the door dwell timer, and clears served requests. It is the decision layer above the motor drive: its motor/door outputs are the only commands the car receives.

## Interface
- DOOR_CYCLES, 8: door-open dwell in clk cycles (≥2)
- CNT_W, 4: dwell counter width; must satisfy 2^CNT_W ≥ DOOR_CYCLES
- clk  in  1  system clock, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- sensor  in  4  floor sensors S1..S4, bit i high while car is at floor i
- hall_up  in  4  up buttons U1..U4; bit 3 ignored (no up at top)
- hall_dn  in  4  down buttons D1..D4; bit 0 ignored (no down at bottom)
- cab  in  4  inside buttons F1..F4
- motor_up  out  1  drive car upward
- motor_down  out  1  drive car downward
- door_open  out  1  door open command
- cur_floor  out  2  last confirmed floor, 0..3
- dir_up  out  1  current/last service direction, 1 = up
- pending  out  4  OR of all pending requests per floor, for the hall display

## Operation
- Pending registers pend_cab, pend_up, pend_dn (4 bits each; pend_up[3] and pend_dn[0] constant 0). Each cycle bit |= button. Presses are level-sampled, so a held button stays pending.
- Clear beats set on the same bit in the same cycle.
- Floor tracking: sensor exactly one-hot → cur_floor = index. All-zero or multi-hot → cur_floor holds. arrival = one-hot and index ≠ cur_floor.
- above = any pending at floors > cur_floor; below = any pending at floors < cur_floor; here = any pending at cur_floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE with here → DOOR. Clears pend_cab/up/dn at cur_floor; dir_up unchanged.
- IDLE, no here: (dir_up & above) | (!below & above) → MOVE_UP, dir_up=1. Else below → MOVE_DOWN, dir_up=0. Else stay.
- MOVE_UP, on arrival at floor f: stop if cab[f] | up[f] | f==3 | (dn[f] & nothing pending above f).
  - Stop → DOOR. Clear cab[f] and up[f]; also clear dn[f] if nothing pending above f, and then dir_up=0.
  - Otherwise stay in MOVE_UP.
- MOVE_DOWN is the mirror: stop on cab[f] | dn[f] | f==0 | (up[f] & nothing below). Clears the mirrored bits, sets dir_up=1 when reversing.
- DOOR: counter loads DOOR_CYCLES−1 on entry and decrements each cycle. At 0 → IDLE.
  - A press of cab[f], or of the hall bit in the service direction at f, during DOOR is not latched and reloads the counter.
- Outputs are Moore decodes of state: motor_up = MOVE_UP, motor_down = MOVE_DOWN, door_open = DOOR.
  - motor_up and motor_down are never both 1.
  - door_open is never 1 with either motor bit.
  - motor_up is never 1 with cur_floor==3; motor_down is never 1 with cur_floor==0.

## Timing
- Reset (async, any state, including mid-move or door open): state IDLE, all pending 0, counter 0, cur_floor 0, dir_up 1.
  - Reset values of all outputs: motor_up=motor_down=door_open=0, cur_floor=0, dir_up=1, pending=0.
- Button high in cycle n → pending bit visible in cycle n+1.
- Press from IDLE: button in cycle n → motor/door output asserted in cycle n+2.
- Arrival sampled at edge k → state DOOR and motor off from cycle k+1. Served bits read 0 from cycle k+1.
- Door is open exactly DOOR_CYCLES cycles absent reloads. The IDLE decision follows in the next cycle.
- Sensor going all-zero between floors has no effect on state.

## Structure
- Package elev_pkg holds:
  - NUM_FLOORS=4
  - floor_t (2-bit)
  - state_t enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR}
  - the stop-condition function, shared with the bench model
- One sub-module, elev_door_timer: load/reload/decrement counter. Inputs load and tick; output done.
- Request registers and direction logic stay in the top module.

## Test plan
- Reset, car at floor 0, cab[2] pulsed 1 cycle:
  - motor_up in cycle n+2;
  - passes floor 1 without stopping;
  - stops at floor 2 with door_open for 8 cycles;
  - then IDLE, pending=0.
- Car at floor 0, hall_dn[3] and hall_up[1]: stops at 1 (up call), then at 3. There dir_up→0 and dn[3] clears.
- Moving up from 0 with hall_dn[1] pending and cab[3] pending: skips floor 1 going up, serves 3, returns down to 1.
- During DOOR at floor 2, cab[2] pressed on count 3: counter reloads, door stays open 8 more cycles, and pend_cab[2] stays 0.
- Assert reset mid-MOVE_UP: all outputs reach reset values immediately. Pending calls are lost, and no motion follows without a new press.
- Multi-hot sensor 4'b0110 while moving: cur_floor holds, no stop. Motor never drives up at floor 3 or down at floor 0 (checked by assertion throughout).

Source files
------------

// File: rtl/elev_pkg.sv
// Shared types and stop-decision helpers for the 4-floor elevator scheduler.
package elev_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  function automatic logic [3:0] above_mask(floor_t f);
    logic [3:0] m;
    m = 4'b1110;
    return m << f;
  endfunction

  function automatic logic [3:0] below_mask(floor_t f);
    logic [3:0] one;
    one = 4'b0001;
    return ~above_mask(f) & ~(one << f);
  endfunction

  // Collective stop rule for a car arriving at f while travelling.
  function automatic logic stop_at(
    floor_t     f,
    logic       going_up,
    logic [3:0] cab,
    logic [3:0] up,
    logic [3:0] dn
  );
    logic [3:0] req;
    req = cab | up | dn;
    if (going_up)
      return cab[f] | up[f] | (f == 2'd3) |
             (dn[f] & ~|(req & above_mask(f)));
    else
      return cab[f] | dn[f] | (f == 2'd0) |
             (up[f] & ~|(req & below_mask(f)));
  endfunction

endpackage

// File: rtl/elev_door_timer.sv
// Door dwell counter: loads DOOR_CYCLES-1, counts down while ticking.
module elev_door_timer #(
  parameter int DOOR_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic tick_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(DOOR_CYCLES - 1);
    else if (tick_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elev_call_scheduler.sv
// Collective (SCAN) call scheduler: latches calls, tracks the car,
// chooses direction, stops at served floors and times the door.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int DOOR_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor,
  input  logic [3:0] hall_up,
  input  logic [3:0] hall_dn,
  input  logic [3:0] cab,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic [3:0] pending
);

  state_t     state_q, state_d;
  floor_t     cur_q, cur_d, f_s;
  logic       dir_q, dir_d;
  logic [3:0] cab_q, up_q, dn_q;
  logic [3:0] cab_d, up_d, dn_d;
  logic [3:0] req_q, hu, hd, fbit, cbit;
  logic [3:0] clr_cab, clr_up, clr_dn;
  logic [3:0] msk_cab, msk_up, msk_dn;
  logic       onehot, arrival, above, below, here;
  logic       rearm, load, done;

  always_comb begin
    f_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (sensor[i]) f_s = floor_t'(i);
  end

  assign onehot  = $onehot(sensor);
  assign arrival = onehot && (f_s != cur_q);
  assign cur_d   = onehot ? f_s : cur_q;

  assign hu    = hall_up & 4'b0111;
  assign hd    = hall_dn & 4'b1110;
  assign req_q = cab_q | up_q | dn_q;
  assign fbit  = 4'(1) << f_s;
  assign cbit  = 4'(1) << cur_q;
  assign above = |(req_q & above_mask(cur_q));
  assign below = |(req_q & below_mask(cur_q));
  assign here  = |(req_q & cbit);

  // A press for the floor being served holds the door instead of latching.
  assign rearm = |(cab & cbit) |
                 (dir_q ? |(hu & cbit) : |(hd & cbit));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    load    = 1'b0;
    clr_cab = '0;
    clr_up  = '0;
    clr_dn  = '0;
    msk_cab = '0;
    msk_up  = '0;
    msk_dn  = '0;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
          load    = 1'b1;
          clr_cab = cbit;
          clr_up  = cbit;
          clr_dn  = cbit;
        end else if ((dir_q & above) | (!below & above)) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (arrival && stop_at(f_s, 1'b1, cab_q, up_q, dn_q)) begin
          state_d = DOOR;
          load    = 1'b1;
          clr_cab = fbit;
          clr_up  = fbit;
          if (~|(req_q & above_mask(f_s))) begin
            clr_dn = fbit;
            dir_d  = 1'b0;
          end
        end
      end
      MOVE_DOWN: begin
        if (arrival && stop_at(f_s, 1'b0, cab_q, up_q, dn_q)) begin
          state_d = DOOR;
          load    = 1'b1;
          clr_cab = fbit;
          clr_dn  = fbit;
          if (~|(req_q & below_mask(f_s))) begin
            clr_up = fbit;
            dir_d  = 1'b1;
          end
        end
      end
      DOOR: begin
        msk_cab = cbit;
        if (dir_q) msk_up = cbit;
        else       msk_dn = cbit;
        if (rearm)     load    = 1'b1;
        else if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cab_d = (cab_q | (cab & ~msk_cab)) & ~clr_cab;
  assign up_d  = (up_q  | (hu  & ~msk_up )) & ~clr_up;
  assign dn_d  = (dn_q  | (hd  & ~msk_dn )) & ~clr_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      dir_q   <= 1'b1;
      cab_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      cab_q   <= cab_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  elev_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load_i(load),
    .tick_i(state_q == DOOR),
    .done_o(done)
  );

  assign motor_up   = (state_q == MOVE_UP);
  assign motor_down = (state_q == MOVE_DOWN);
  assign door_open  = (state_q == DOOR);
  assign cur_floor  = cur_q;
  assign dir_up     = dir_q;
  assign pending    = req_q;

endmodule
